// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  // Flag vector bit positions, ordered Z C N O = [3:0].
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_O = 0;

  localparam logic [4:0] FS_ADD16   = 5'b10100;
  localparam logic [4:0] FS_SUB16   = 5'b10110;
  localparam logic [4:0] FS_PASSA16 = 5'b10000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] j;

  // Scan from ptr upward modulo NUM_REQ and take the first request seen.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    j           = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!grant_valid && req[j]) begin
        grant[j]    = 1'b1;
        grant_idx   = j;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters.
// Each accepted op runs IDLE -> EXEC -> RESP: the ALU is driven for exactly one
// cycle in EXEC and the result is returned in RESP.
// Optional macro ALU_ARB_LOCK_EN adds ReqLock, letting a requester keep the ALU
// (and its carry flag) private across a chain of ops.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FUNSEL_W = 5,
  parameter int unsigned FLAG_W   = 4
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [NUM_REQ-1:0]           ReqValid,
  input  logic [NUM_REQ*DATA_W-1:0]    ReqA,
  input  logic [NUM_REQ*DATA_W-1:0]    ReqB,
  input  logic [NUM_REQ*FUNSEL_W-1:0]  ReqFunSel,
  input  logic [NUM_REQ-1:0]           ReqWF,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]           ReqLock,
`endif
  output logic [NUM_REQ-1:0]           ReqReady,
  output logic [NUM_REQ-1:0]           RespValid,
  output logic [DATA_W-1:0]            RespData,
  output logic [FLAG_W-1:0]            RespFlags,
  output logic [DATA_W-1:0]            AluA,
  output logic [DATA_W-1:0]            AluB,
  output logic [FUNSEL_W-1:0]          AluFunSel,
  output logic                         AluWF,
  input  logic [DATA_W-1:0]            AluOut,
  input  logic [FLAG_W-1:0]            AluFlags,
  output logic                         Busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                state_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      gnt_idx_q;
  logic [DATA_W-1:0]     op_a_q;
  logic [DATA_W-1:0]     op_b_q;
  logic [FUNSEL_W-1:0]   op_fs_q;
  logic                  op_wf_q;
  logic [NUM_REQ-1:0]    resp_valid_q;
  logic [DATA_W-1:0]     resp_data_q;
  logic [FLAG_W-1:0]     resp_flags_q;

  logic [NUM_REQ-1:0]    arb_req;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic                  accept;
  logic [IDX_W-1:0]      rr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req         (arb_req),
    .ptr         (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

`ifdef ALU_ARB_LOCK_EN
  logic             lock_active_q;
  logic             op_lock_q;
  logic [IDX_W-1:0] lock_owner_q;

  // Track lock ownership; a non-locking op releases the lock once it has responded.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      lock_active_q <= 1'b0;
      op_lock_q     <= 1'b0;
      lock_owner_q  <= '0;
    end else if (accept) begin
      op_lock_q <= ReqLock[grant_idx];
      if (ReqLock[grant_idx]) begin
        lock_active_q <= 1'b1;
        lock_owner_q  <= grant_idx;
      end
    end else if (state_q == StResp && !op_lock_q) begin
      lock_active_q <= 1'b0;
    end
  end

  // While locked, only the owner is visible to the arbiter.
  always_comb begin
    arb_req = ReqValid;
    if (lock_active_q) arb_req = ReqValid & (NUM_REQ'(1) << lock_owner_q);
  end
`else
  assign arb_req = ReqValid;
`endif

  assign accept  = (state_q == StIdle) && grant_valid;
  assign rr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  // Main FSM; operand registers hold between ops so the ALU inputs never glitch.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      gnt_idx_q    <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_fs_q      <= FUNSEL_W'(FS_PASSA16);
      op_wf_q      <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_flags_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_a_q    <= ReqA[grant_idx*DATA_W +: DATA_W];
            op_b_q    <= ReqB[grant_idx*DATA_W +: DATA_W];
            op_fs_q   <= ReqFunSel[grant_idx*FUNSEL_W +: FUNSEL_W];
            op_wf_q   <= ReqWF[grant_idx];
            gnt_idx_q <= grant_idx;
            rr_ptr_q  <= rr_next;
            state_q   <= StExec;
          end
        end
        StExec: begin
          resp_data_q  <= AluOut;
          op_wf_q      <= 1'b0;
          resp_valid_q <= NUM_REQ'(1) << gnt_idx_q;
          state_q      <= StResp;
        end
        StResp: begin
          resp_valid_q <= '0;
          resp_flags_q <= AluFlags;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ReqReady  = accept ? grant : '0;
  assign RespValid = resp_valid_q;
  assign RespData  = resp_data_q;
  // In RESP the ALU flags already include this op's update.
  assign RespFlags = (state_q == StResp) ? AluFlags : resp_flags_q;
  assign AluA      = op_a_q;
  assign AluB      = op_b_q;
  assign AluFunSel = op_fs_q;
  assign AluWF     = op_wf_q;
  assign Busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int N = 2;

  logic            Clock = 1'b0;
  logic            Reset = 1'b0;
  logic [N-1:0]    ReqValid, ReqWF, ReqReady, RespValid;
  logic [N*16-1:0] ReqA, ReqB;
  logic [N*5-1:0]  ReqFunSel;
  logic [15:0]     RespData, AluA, AluB, AluOut;
  logic [3:0]      RespFlags, AluFlags;
  logic [4:0]      AluFunSel;
  logic            AluWF, Busy;
`ifdef ALU_ARB_LOCK_EN
  logic [N-1:0]    ReqLock = '0;
`endif

  always #5 Clock = ~Clock;

  alu_arbiter dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .ReqValid  (ReqValid),
    .ReqA      (ReqA),
    .ReqB      (ReqB),
    .ReqFunSel (ReqFunSel),
    .ReqWF     (ReqWF),
`ifdef ALU_ARB_LOCK_EN
    .ReqLock   (ReqLock),
`endif
    .ReqReady  (ReqReady),
    .RespValid (RespValid),
    .RespData  (RespData),
    .RespFlags (RespFlags),
    .AluA      (AluA),
    .AluB      (AluB),
    .AluFunSel (AluFunSel),
    .AluWF     (AluWF),
    .AluOut    (AluOut),
    .AluFlags  (AluFlags),
    .Busy      (Busy)
  );

  // ALU behaviour: returns {result, new flags}.
  function automatic logic [19:0] alu_eval(logic [15:0] a, logic [15:0] b, logic [4:0] fs,
                                           logic [3:0] f);
    logic [16:0] s;
    logic [15:0] r;
    logic [3:0]  fo;
    fo = f;
    s  = '0;
    case (fs)
      FS_ADD16: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        fo[FLAG_C] = s[16];
        fo[FLAG_O] = (a[15] == b[15]) && (r[15] != a[15]);
      end
      FS_SUB16: begin
        s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        r = s[15:0];
        fo[FLAG_C] = s[16];
        fo[FLAG_O] = (a[15] != b[15]) && (r[15] != a[15]);
      end
      default: r = a;
    endcase
    fo[FLAG_Z] = (r == 16'h0000);
    fo[FLAG_N] = r[15];
    return {r, fo};
  endfunction

  logic [3:0] alu_flags_r = 4'b0000;
  logic [3:0] alu_nf;
  always_comb {AluOut, alu_nf} = alu_eval(AluA, AluB, AluFunSel, alu_flags_r);
  assign AluFlags = alu_flags_r;
  always @(posedge Clock) if (AluWF) alu_flags_r <= alu_nf;

  // Transaction-level reference: last accepted op, its cycle, and the pointer.
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          acc_cyc;
  int          rr;
  int          m_idx;
  logic [15:0] m_a, m_b, m_data;
  logic [4:0]  m_fs;
  logic        m_wf;
  logic [3:0]  m_flags = 4'b0000;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    acc_cyc = -100;
    rr      = 0;
    m_idx   = 0;
    m_a     = '0;
    m_b     = '0;
    m_fs    = FS_PASSA16;
    m_wf    = 1'b0;
  endtask

  // Called just after a negedge with inputs applied: compare, then advance the model.
  task automatic settle();
    int ph, g;
    logic [N-1:0] exp_ready, exp_resp;
    logic [3:0]   nf;
    #1;
    if (!Reset) model_reset();
    ph = cyc - acc_cyc;
    g  = -1;
    exp_ready = '0;
    exp_resp  = '0;
    if (Reset && !(ph == 1 || ph == 2)) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && ReqValid[(rr + k) % N]) g = (rr + k) % N;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    if (ph == 2) exp_resp[m_idx] = 1'b1;
    chk("ReqReady", ReqReady, exp_ready);
    chk("RespValid", RespValid, exp_resp);
    chk("Busy", Busy, (ph == 1 || ph == 2));
    chk("AluWF", AluWF, (ph == 1) ? m_wf : 1'b0);
    chk("AluA", AluA, m_a);
    chk("AluB", AluB, m_b);
    chk("AluFunSel", AluFunSel, m_fs);
    if (ph == 2) begin
      chk("RespData", RespData, m_data);
      chk("RespFlags", RespFlags, m_flags);
    end
    if (g >= 0) begin
      acc_cyc = cyc;
      m_idx   = g;
      m_a     = ReqA[g*16 +: 16];
      m_b     = ReqB[g*16 +: 16];
      m_fs    = ReqFunSel[g*5 +: 5];
      m_wf    = ReqWF[g];
      rr      = (g + 1) % N;
    end
    if (ph == 1) begin
      {m_data, nf} = alu_eval(m_a, m_b, m_fs, m_flags);
      if (m_wf) m_flags = nf;
    end
    cyc++;
  endtask

  task automatic advance();
    @(negedge Clock);
  endtask

  task automatic set_req(int i, logic v, logic [15:0] a, logic [15:0] b, logic [4:0] fs,
                         logic wf);
    ReqValid[i]       = v;
    ReqA[i*16 +: 16]  = a;
    ReqB[i*16 +: 16]  = b;
    ReqFunSel[i*5 +: 5] = fs;
    ReqWF[i]          = wf;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ReqValid  = '0;
    ReqWF     = '0;
    ReqA      = '0;
    ReqB      = '0;
    ReqFunSel = '0;
    cyc       = 0;
    model_reset();
    repeat (2) @(negedge Clock);

    // Reset values.
    chk("rst ReqReady", ReqReady, 0);
    chk("rst RespValid", RespValid, 0);
    chk("rst RespData", RespData, 0);
    chk("rst RespFlags", RespFlags, 0);
    chk("rst AluA", AluA, 0);
    chk("rst AluB", AluB, 0);
    chk("rst AluFunSel", AluFunSel, 5'b10000);
    chk("rst AluWF", AluWF, 0);
    chk("rst Busy", Busy, 0);
    Reset = 1'b1;
    advance();

    // Single op: 0x7FFF + 1 overflows into the sign bit.
    set_req(0, 1'b1, 16'h7FFF, 16'h0001, FS_ADD16, 1'b1);
    settle();
    chk("single ready", ReqReady, 2'b01);
    advance();
    ReqValid = '0;
    settle();
    chk("single exec wf", AluWF, 1'b1);
    advance();
    settle();
    chk("single resp valid", RespValid, 2'b01);
    chk("single resp data", RespData, 16'h8000);
    chk("single flag N", RespFlags[FLAG_N], 1'b1);
    chk("single flag O", RespFlags[FLAG_O], 1'b1);
    chk("single flag Z", RespFlags[FLAG_Z], 1'b0);
    advance();
    settle();
    chk("single after wf", AluWF, 1'b0);
    advance();

    // Pass A with WF=0: flags must stay Z0 C0 N1 O1.
    set_req(0, 1'b1, 16'h0000, 16'h1234, FS_PASSA16, 1'b0);
    settle();
    chk("nowf ready", ReqReady, 2'b01);
    advance();
    ReqValid = '0;
    settle();
    chk("nowf exec wf", AluWF, 1'b0);
    advance();
    settle();
    chk("nowf resp data", RespData, 16'h0000);
    chk("nowf resp flags", RespFlags, 4'b0011);
    advance();

    // Reset in EXEC discards the op.
    set_req(1, 1'b1, 16'h0003, 16'h0004, FS_ADD16, 1'b1);
    settle();
    advance();
    ReqValid = '0;
    Reset    = 1'b0;
    settle();
    chk("rstmid busy", Busy, 1'b0);
    chk("rstmid wf", AluWF, 1'b0);
    advance();
    settle();
    chk("rstmid resp valid", RespValid, 2'b00);
    chk("rstmid funsel", AluFunSel, 5'b10000);
    advance();
    Reset = 1'b1;

    // Idle with no requests.
    repeat (20) begin
      settle();
      advance();
    end
    chk("idle flags kept", AluFlags, 4'b0011);

    // Contention: both held high, grants alternate starting at requester 0.
    set_req(0, 1'b1, 16'h0001, 16'h0002, FS_ADD16, 1'b1);
    set_req(1, 1'b1, 16'h0005, 16'h0003, FS_SUB16, 1'b1);
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("cont ready", ReqReady, (k % 2) ? 2'b10 : 2'b01);
      advance();
      settle();
      advance();
      settle();
      chk("cont resp valid", RespValid, (k % 2) ? 2'b10 : 2'b01);
      chk("cont resp data", RespData, (k % 2) ? 16'h0002 : 16'h0003);
      advance();
    end
    ReqValid = '0;

    // Randomized traffic against the reference.
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        logic [4:0] fs;
        case ($urandom_range(0, 2))
          0:       fs = FS_ADD16;
          1:       fs = FS_SUB16;
          default: fs = FS_PASSA16;
        endcase
        set_req(i, ($urandom_range(0, 1) == 1), 16'($urandom), 16'($urandom), fs,
                ($urandom_range(0, 1) == 1));
      end
      settle();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 16-bit ArithmeticLogicUnit between NUM_REQ requesters (e.g. control-unit datapath, address-calculation unit).
- Accepts a request with operands, FunSel and WF; drives the ALU for exactly one clock; returns ALUOut and FlagsOut to the requester.
- Arbitration is round-robin. ALU FunSel/WF are held in a non-disturbing state when no operation is running.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_W, 16, operand/result width.
- FUNSEL_W, 5, ALU function-select width.
- FLAG_W, 4, flag width; bit order Z C N O = [3:0].

Ports:
- Clock  in  1  single system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ReqValid  in  NUM_REQ  per-requester request valid.
- ReqA  in  NUM_REQ*DATA_W  flattened operand A; requester i at [i*DATA_W +: DATA_W].
- ReqB  in  NUM_REQ*DATA_W  flattened operand B, same packing.
- ReqFunSel  in  NUM_REQ*FUNSEL_W  flattened function select.
- ReqWF  in  NUM_REQ  per-requester flag-write enable.
- ReqReady  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- RespValid  out  NUM_REQ  one-hot, one-cycle response pulse.
- RespData  out  DATA_W  result; valid while any RespValid bit is high.
- RespFlags  out  FLAG_W  ALU FlagsOut sampled in RESP.
- AluA  out  DATA_W  to ALU A.
- AluB  out  DATA_W  to ALU B.
- AluFunSel  out  FUNSEL_W  to ALU FunSel.
- AluWF  out  1  to ALU WF.
- AluOut  in  DATA_W  from ALU ALUOut.
- AluFlags  in  FLAG_W  from ALU FlagsOut.
- Busy  out  1  high in EXEC and RESP.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE, rr_ptr=0.
  - ReqReady=0, RespValid=0, RespData=0, RespFlags=0.
  - AluA=0, AluB=0, AluFunSel=5'b10000 (pass A), AluWF=0, Busy=0.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any ReqValid is set, grant the first set bit searching from rr_ptr upward, modulo NUM_REQ.
  - ReqReady[g] is asserted combinationally in the same cycle.
  - At the clock edge: latch A, B, FunSel and WF of g into the operand registers, latch g; rr_ptr <= (g+1) mod NUM_REQ; go to EXEC.
  - Requester g may drop or change its inputs after the ReqReady cycle.
- EXEC (exactly one cycle):
  - AluA/AluB/AluFunSel come from the latched registers; AluWF = latched WF.
  - At the edge: RespData <= AluOut (combinational ALU result). The ALU updates its own flags on the same edge if WF=1. Go to RESP.
- RESP (one cycle):
  - RespValid[g]=1.
  - RespFlags is registered from AluFlags at the EXEC->RESP edge plus one, i.e. sampled combinationally from the ALU in RESP, so it reflects the updated flags.
  - AluWF=0. Next state is IDLE. No acceptance happens in RESP.
- Outside EXEC: AluWF=0 always. AluA/AluB/AluFunSel hold their last value, so flag-independent ALU ops cannot corrupt the flags.
- Latency: acceptance edge -> RespValid two cycles later. Throughput: one op per 3 cycles.
- Simultaneous requests: rr_ptr decides. A requester holding ReqValid high continuously is served at most once per NUM_REQ grants while others are waiting.
- A request in flight always completes. A requester dropping ReqValid after acceptance has no effect.
- Reset mid-operation: the in-flight op is discarded, no RespValid is issued. The ALU's internal flags are not reset by this block.
- Carry-in ops (FunSel x0101, rotates) use the ALU's current carry; ordering across requesters is not guaranteed without the lock feature.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- With the macro:
  - Adds input ReqLock [NUM_REQ].
  - A grant whose ReqLock=1 sets lock_owner=g, lock_active=1. While locked, only lock_owner may be granted; other requests wait.
  - A granted op with ReqLock=0 clears the lock after it completes.
  - Reset clears the lock.
  - Purpose: multi-word add/ADC chains keep the carry private.
- Without the macro: the ReqLock port is absent and arbitration is pure round-robin.

Decomposition:
- Package alu_arb_pkg holds:
  - state enum (IDLE, EXEC, RESP);
  - flag-bit index constants FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_O=0;
  - FunSel constants used in tests (FS_ADD16=5'b10100, FS_SUB16=5'b10110, FS_PASSA16=5'b10000).
- One sub-module: rr_arbiter (combinational request vector + pointer -> one-hot grant plus index).

Test Plan:
- Single op: requester 0 sends A=0x7FFF, B=0x0001, FunSel=10100, WF=1 -> ReqReady[0] in cycle 0, AluWF=1 only in cycle 1, RespValid[0] in cycle 2 with RespData=0x8000, RespFlags N=1, O=1, Z=0.
- Contention: both ReqValid held high after reset, req0 A=1,B=2 add, req1 A=5,B=3 sub -> grant order 0,1,0,1; results 0x0003 and 0x0002 alternate.
- WF=0 op: pass A=0x0000 with FunSel=10000 -> RespData=0. RespFlags equals the flags before the op; AluWF never asserted.
- Reset mid-op: assert Reset in EXEC -> no RespValid, state IDLE, rr_ptr=0, all outputs at reset values next cycle.
- Idle: no ReqValid for 20 cycles -> AluWF=0, Busy=0, no ReqReady, flags unchanged.
- ALU_ARB_LOCK_EN: req1 lock=1 add, then both requesting -> req1 granted twice in a row; after req1 lock=0 completes, req0 is granted next.
